// File: rtl/player_pkg.sv
// Types and constants shared by the player cannon and its laser projectile.
package player_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [3:0] {
    LS_IDLE     = 4'b0001,
    LS_FLY      = 4'b0010,
    LS_EXPLODE  = 4'b0100,
    LS_COOLDOWN = 4'b1000
  } laser_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/player_laser_frame_countdown.sv
// Frame-based countdown: load a frame count, then done fires on the tick that
// exhausts it (or immediately when the loaded count is zero).
module frame_countdown (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       frame_tick_i,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (frame_tick_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero count is already expired, so a zero-length phase lasts one cycle.
  assign done_o = (cnt_q == 4'd0) || (frame_tick_i && (cnt_q == 4'd1));

endmodule

// File: rtl/player_laser.sv
// Player laser: launches one projectile from the cannon, moves it up per frame,
// reports hit/miss, and renders the laser or its explosion for the compositor.
module player_laser
  import player_pkg::*;
#(
  parameter logic [9:0]  start_y_p         = 10'd440,
  parameter logic [9:0]  top_y_p           = 10'd16,
  parameter logic [3:0]  speed_p           = 4'd4,
  parameter logic [3:0]  laser_width_p     = 4'd2,
  parameter logic [3:0]  laser_height_p    = 4'd8,
  parameter logic [3:0]  explode_frames_p  = 4'd6,
  parameter logic [3:0]  cooldown_frames_p = 4'd10,
  parameter logic [11:0] color_p           = 12'hFFF,
  parameter logic [11:0] explode_color_p   = 12'hF80
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       shoot_i,
  input  logic [9:0] gun_pos_i,
  input  logic       frame_tick_i,
  input  logic       hit_enemy_i,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  output logic       ready_o,
  output logic       active_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic       laser_pixel_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [3:0] state_o
);

  localparam logic [9:0]  HalfW     = {6'd0, laser_width_p} >> 1;
  // Below this row another step would carry the laser past the playfield top.
  localparam logic [10:0] MissLimit = {1'b0, top_y_p} + {7'd0, speed_p};

  laser_state_e state_q, state_d;
  logic [9:0]   x_q, x_d, y_q, y_d;
  logic         hit_q, hit_d, miss_q, miss_d;
  logic         cnt_load;
  logic [3:0]   cnt_val;
  logic         cnt_done;
  logic         pix_q, pix_d;
  rgb12_t       rgb_q, rgb_d;
  logic         in_x, in_y;

  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : 10'd0;
  endfunction

  frame_countdown u_countdown (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (cnt_load),
    .load_val_i  (cnt_val),
    .frame_tick_i(frame_tick_i),
    .done_o      (cnt_done)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = cooldown_frames_p;
    case (state_q)
      LS_IDLE: begin
        if (shoot_i) begin
          x_d     = sat_sub(gun_pos_i, HalfW);
          y_d     = start_y_p;
          state_d = LS_FLY;
        end
      end
      LS_FLY: begin
        // A hit outranks both movement and retirement in the same cycle.
        if (hit_enemy_i) begin
          hit_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = explode_frames_p;
          state_d  = LS_EXPLODE;
        end else if (frame_tick_i) begin
          if ({1'b0, y_q} < MissLimit) begin
            miss_d   = 1'b1;
            cnt_load = 1'b1;
            state_d  = LS_COOLDOWN;
          end else begin
            y_d = y_q - {6'd0, speed_p};
          end
        end
      end
      LS_EXPLODE: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          state_d  = LS_COOLDOWN;
        end
      end
      LS_COOLDOWN: begin
        if (cnt_done) begin
          state_d = LS_IDLE;
        end
      end
      default: state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q    <= 10'd0;
      y_q    <= start_y_p;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  // Pixel stage: 11-bit bounds so a laser at the right edge cannot wrap.
  always_comb begin
    in_x  = ({1'b0, hcount_i} >= {1'b0, x_q}) &&
            ({1'b0, hcount_i} <  ({1'b0, x_q} + {7'd0, laser_width_p}));
    in_y  = ({1'b0, vcount_i} >= {1'b0, y_q}) &&
            ({1'b0, vcount_i} <  ({1'b0, y_q} + {7'd0, laser_height_p}));
    pix_d = ((state_q == LS_FLY) || (state_q == LS_EXPLODE)) && in_x && in_y;
    rgb_d = '0;
    if (pix_d) begin
      rgb_d = (state_q == LS_EXPLODE) ? rgb12_t'(explode_color_p) : rgb12_t'(color_p);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pix_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      pix_q <= pix_d;
      rgb_q <= rgb_d;
    end
  end

  assign ready_o       = (state_q == LS_IDLE);
  assign active_o      = (state_q == LS_FLY);
  assign state_o       = state_q;
  assign laser_x_o     = x_q;
  assign laser_y_o     = y_q;
  assign hit_o         = hit_q;
  assign miss_o        = miss_q;
  assign laser_pixel_o = pix_q;
  assign laser_red_o   = rgb_q.r;
  assign laser_green_o = rgb_q.g;
  assign laser_blue_o  = rgb_q.b;

endmodule

// File: tb/tb_player_laser.sv
// Bench for player_laser: per-cycle reference model plus directed literal checks.
module tb_player_laser;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       shoot_i = 1'b0;
  logic [9:0] gun_pos_i = '0;
  logic       frame_tick_i = 1'b0;
  logic       hit_enemy_i = 1'b0;
  logic [9:0] hcount_i = '0;
  logic [9:0] vcount_i = '0;
  logic       ready_o, active_o, hit_o, miss_o, laser_pixel_o;
  logic [9:0] laser_x_o, laser_y_o;
  logic [3:0] laser_red_o, laser_green_o, laser_blue_o, state_o;

  player_laser dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .shoot_i      (shoot_i),
    .gun_pos_i    (gun_pos_i),
    .frame_tick_i (frame_tick_i),
    .hit_enemy_i  (hit_enemy_i),
    .hcount_i     (hcount_i),
    .vcount_i     (vcount_i),
    .ready_o      (ready_o),
    .active_o     (active_o),
    .laser_x_o    (laser_x_o),
    .laser_y_o    (laser_y_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o),
    .laser_pixel_o(laser_pixel_o),
    .laser_red_o  (laser_red_o),
    .laser_green_o(laser_green_o),
    .laser_blue_o (laser_blue_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_miss = 0;
  int miss_y = -1;

  // Model phases: 0 ready, 1 flying, 2 exploding, 3 cooling down.
  int m_mode = 0, m_x = 0, m_y = 440, m_left = 0, m_rgb = 0;
  bit m_hit = 0, m_miss = 0, m_pix = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    cyc();
    if (miss_o) begin
      n_miss++;
      miss_y = laser_y_o;
    end
    frame_tick_i = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix_at(input int h, input int v, input logic exp_pix, input logic [11:0] exp_rgb);
    hcount_i = 10'(h);
    vcount_i = 10'(v);
    cyc();
    chk("pixel_lit", laser_pixel_o, exp_pix);
    chk("rgb_lit", {laser_red_o, laser_green_o, laser_blue_o}, exp_rgb);
  endtask

  // Reference model, evaluated with the inputs present at each rising edge.
  initial forever begin
    @(posedge clk or posedge reset_i);
    if (reset_i) begin
      m_mode = 0; m_x = 0; m_y = 440; m_left = 0;
      m_hit = 0; m_miss = 0; m_pix = 0; m_rgb = 0;
    end else begin
      m_pix = (m_mode == 1 || m_mode == 2) &&
              int'(hcount_i) >= m_x && int'(hcount_i) < m_x + 2 &&
              int'(vcount_i) >= m_y && int'(vcount_i) < m_y + 8;
      m_rgb = !m_pix ? 0 : (m_mode == 1 ? 'hFFF : 'hF80);
      m_hit = 0;
      m_miss = 0;
      case (m_mode)
        0: if (shoot_i) begin
             m_x = (int'(gun_pos_i) >= 1) ? int'(gun_pos_i) - 1 : 0;
             m_y = 440;
             m_mode = 1;
           end
        1: if (hit_enemy_i) begin
             m_hit = 1; m_mode = 2; m_left = 6;
           end else if (frame_tick_i) begin
             if (m_y - 4 < 16) begin
               m_miss = 1; m_mode = 3; m_left = 10;
             end else begin
               m_y = m_y - 4;
             end
           end
        2: begin
             if (frame_tick_i && m_left > 0) m_left--;
             if (m_left == 0) begin
               m_mode = 3; m_left = 10;
             end
           end
        default: begin
             if (frame_tick_i && m_left > 0) m_left--;
             if (m_left == 0) m_mode = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("onehot", $countones(state_o), 1);
    if (!reset_i) begin
      chk("state", state_o, 1 << m_mode);
      chk("ready", ready_o, m_mode == 0);
      chk("active", active_o, m_mode == 1);
      chk("x", laser_x_o, m_x);
      chk("y", laser_y_o, m_y);
      chk("hit", hit_o, m_hit);
      chk("miss", miss_o, m_miss);
      chk("pixel", laser_pixel_o, m_pix);
      chk("rgb", {laser_red_o, laser_green_o, laser_blue_o}, m_rgb);
    end
  end

  initial begin
    cyc();
    cyc();
    chk("rst_state", state_o, 4'b0001);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_active", active_o, 1'b0);
    chk("rst_x", laser_x_o, 10'd0);
    chk("rst_y", laser_y_o, 10'd440);
    chk("rst_pixel", laser_pixel_o, 1'b0);
    reset_i = 1'b0;

    // Idle hit is ignored; then launch from the screen centre.
    hit_enemy_i = 1'b1;
    cyc();
    hit_enemy_i = 1'b0;
    chk("idle_hit", hit_o, 1'b0);
    shoot_i = 1'b1;
    gun_pos_i = 10'd320;
    cyc();
    chk("launch_active", active_o, 1'b1);
    chk("launch_x", laser_x_o, 10'd319);
    chk("launch_y", laser_y_o, 10'd440);
    chk("launch_state", state_o, 4'b0010);

    // Held trigger and a moved cannon must not disturb the flying laser.
    gun_pos_i = 10'd100;
    ticks(10);
    chk("fly10_y", laser_y_o, 10'd400);
    chk("fly10_x", laser_x_o, 10'd319);
    shoot_i = 1'b0;

    pix_at(319, 400, 1'b1, 12'hFFF);
    pix_at(320, 407, 1'b1, 12'hFFF);
    pix_at(321, 400, 1'b0, 12'h000);
    pix_at(319, 408, 1'b0, 12'h000);
    pix_at(318, 403, 1'b0, 12'h000);
    pix_at(320, 399, 1'b0, 12'h000);

    // Hit coinciding with a frame tick at y=300.
    ticks(25);
    chk("pre_hit_y", laser_y_o, 10'd300);
    hit_enemy_i = 1'b1;
    frame_tick_i = 1'b1;
    cyc();
    hit_enemy_i = 1'b0;
    frame_tick_i = 1'b0;
    chk("hit_pulse", hit_o, 1'b1);
    chk("hit_nomiss", miss_o, 1'b0);
    chk("hit_y", laser_y_o, 10'd300);
    chk("hit_state", state_o, 4'b0100);
    cyc();
    chk("hit_once", hit_o, 1'b0);
    pix_at(319, 300, 1'b1, 12'hF80);
    pix_at(320, 307, 1'b1, 12'hF80);

    ticks(5);
    chk("explode5", state_o, 4'b0100);
    tick();
    chk("explode6", state_o, 4'b1000);
    pix_at(319, 300, 1'b0, 12'h000);
    hit_enemy_i = 1'b1;
    cyc();
    hit_enemy_i = 1'b0;
    ticks(9);
    chk("cool9_ready", ready_o, 1'b0);
    tick();
    chk("cool10_ready", ready_o, 1'b1);

    // Launch at the left edge clamps to column 0, then fly to the top.
    gun_pos_i = 10'd0;
    shoot_i = 1'b1;
    cyc();
    shoot_i = 1'b0;
    chk("sat_x", laser_x_o, 10'd0);
    n_miss = 0;
    ticks(106);
    chk("top_y", laser_y_o, 10'd16);
    chk("top_nomiss", n_miss, 0);
    tick();
    chk("miss_count", n_miss, 1);
    chk("miss_at_y", miss_y, 16);
    chk("miss_state", state_o, 4'b1000);
    ticks(9);
    chk("miss_cool9", ready_o, 1'b0);
    tick();
    chk("miss_once", n_miss, 1);
    chk("miss_cool10", ready_o, 1'b1);

    // Reset while flying aborts at once without any pulse.
    gun_pos_i = 10'd5;
    shoot_i = 1'b1;
    cyc();
    shoot_i = 1'b0;
    chk("x_gun5", laser_x_o, 10'd4);
    ticks(3);
    reset_i = 1'b1;
    hit_enemy_i = 1'b1;
    #1;
    chk("arst_state", state_o, 4'b0001);
    chk("arst_active", active_o, 1'b0);
    chk("arst_hit", hit_o, 1'b0);
    chk("arst_miss", miss_o, 1'b0);
    chk("arst_y", laser_y_o, 10'd440);
    cyc();
    chk("arst_hit2", hit_o, 1'b0);
    reset_i = 1'b0;
    hit_enemy_i = 1'b0;
    cyc();
    chk("post_rst_state", state_o, 4'b0001);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
